// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//
// Sequences one decoded instruction at a time through the register file
// and the ALU. It reads both source operands, presents them to the ALU with
// a valid/ready handshake, and optionally writes the ALU result back.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   instr_valid/ready     decoded-instruction handshake
//   instr_rs1/rs2/rd      source and destination register indices
//   instr_wb              instruction produces a write-back
//   rf_addr1/rf_addr2     register file read addresses
//   rf_data1/rf_data2     register file read data (one cycle after address)
//   rf_wr_en/addr/data    register file write port
//   op_valid/ready        operand handshake towards the ALU
//   op_a/op_b             operands
//   res_valid/res_data    ALU result
//   err                   one-cycle pulse for an out-of-range index

module regfile_access_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic              instr_wb,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPT    = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_WAITRES = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;

    localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(NUM_REGS);

    logic [2:0]        state;
    logic [ADDR_W-1:0] rd_q;
    logic              wb_q;
    logic              rs1_bad;
    logic              rs2_bad;
    logic              rd_bad;
    logic [DATA_W-1:0] res_q;

    // The read addresses are registered at the accept edge, so they are
    // already valid during READ and naturally hold afterwards. Range checks
    // are done once at accept and remembered as flags, so that err and the
    // operand/write suppression all agree on the same decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rf_addr1 <= '0;
            rf_addr2 <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            rs1_bad  <= 1'b0;
            rs2_bad  <= 1'b0;
            rd_bad   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            res_q    <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        rf_addr1 <= instr_rs1;
                        rf_addr2 <= instr_rs2;
                        rd_q     <= instr_rd;
                        wb_q     <= instr_wb;
                        rs1_bad  <= (instr_rs1 >= REG_LIMIT);
                        rs2_bad  <= (instr_rs2 >= REG_LIMIT);
                        rd_bad   <= (instr_rd  >= REG_LIMIT);
                        err      <= (instr_rs1 >= REG_LIMIT) ||
                                    (instr_rs2 >= REG_LIMIT) ||
                                    (instr_rd  >= REG_LIMIT);
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    state <= S_CAPT;
                end
                S_CAPT: begin
                    // Register file data for the addresses issued in READ
                    // is valid now; an out-of-range source reads as zero.
                    op_a  <= rs1_bad ? '0 : rf_data1;
                    op_b  <= rs2_bad ? '0 : rf_data2;
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (op_ready) begin
                        state <= wb_q ? S_WAITRES : S_IDLE;
                    end
                end
                S_WAITRES: begin
                    if (res_valid) begin
                        res_q <= res_data;
                        state <= rd_bad ? S_IDLE : S_WRITE;
                    end
                end
                S_WRITE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake and write strobes decode directly from the state, so reset
    // forces them to their idle values immediately. The write port is zeroed
    // whenever the strobe is low.
    assign instr_ready = (state == S_IDLE);
    assign op_valid    = (state == S_ISSUE);
    assign rf_wr_en    = (state == S_WRITE);
    assign rf_wr_addr  = rf_wr_en ? rd_q  : '0;
    assign rf_wr_data  = rf_wr_en ? res_q : '0;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl
//
// Directed bench for regfile_access_ctrl. The bench owns a small register
// file model (registered read, one-cycle latency) and drives the ALU side
// by hand so each expected value can be derived step by step.

module tb_regfile_access_ctrl;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 8;

    logic              clk;
    logic              rst;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] instr_rs1;
    logic [ADDR_W-1:0] instr_rs2;
    logic [ADDR_W-1:0] instr_rd;
    logic              instr_wb;
    logic [ADDR_W-1:0] rf_addr1;
    logic [ADDR_W-1:0] rf_addr2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              err;

    logic [DATA_W-1:0] regs [0:NUM_REGS-1];
    int                wr_count;
    int                hs_count;
    int                checks;
    int                failures;
    int                wr_base;
    int                hs_base;

    regfile_access_ctrl #(
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_rs1  (instr_rs1),
        .instr_rs2  (instr_rs2),
        .instr_rd   (instr_rd),
        .instr_wb   (instr_wb),
        .rf_addr1   (rf_addr1),
        .rf_addr2   (rf_addr2),
        .rf_data1   (rf_data1),
        .rf_data2   (rf_data2),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: reset preloads r1=0x12, r2=0x34, others zero.
    // Out-of-range reads return 0xEE so operand zeroing is observable.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            regs[1]  <= 8'h12;
            regs[2]  <= 8'h34;
            rf_data1 <= '0;
            rf_data2 <= '0;
        end else begin
            rf_data1 <= (rf_addr1 < 8'(NUM_REGS)) ? regs[rf_addr1[2:0]] : 8'hEE;
            rf_data2 <= (rf_addr2 < 8'(NUM_REGS)) ? regs[rf_addr2[2:0]] : 8'hEE;
            if (rf_wr_en) regs[rf_wr_addr[2:0]] <= rf_wr_data;
        end
    end

    // Count write strobes and operand handshakes seen at clock edges.
    always @(posedge clk) begin
        if (rf_wr_en) wr_count <= wr_count + 1;
        if (op_valid && op_ready) hs_count <= hs_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction and holds it through the accept edge.
    task automatic applyStimulus(input logic [7:0] rs1, input logic [7:0] rs2,
                                 input logic [7:0] rd, input logic wb);
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_rd    = rd;
        instr_wb    = wb;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        wr_count    = 0;
        hs_count    = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        instr_rd    = '0;
        instr_wb    = 1'b0;
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        res_data    = '0;
        #12;
        checkOutput("rst_instr_ready", instr_ready, 1);
        checkOutput("rst_op_valid", op_valid, 0);
        checkOutput("rst_wr_en", rf_wr_en, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_op_a", op_a, 0);
        checkOutput("rst_addr1", rf_addr1, 0);
        checkOutput("rst_wr_data", rf_wr_data, 0);
        step();
        rst = 1'b0;
        step();

        // Simple op: r3 = 0x46 from operands r1, r2.
        wr_base  = wr_count;
        op_ready = 1'b1;
        applyStimulus(8'd1, 8'd2, 8'd3, 1'b1);
        checkOutput("t1_addr1", rf_addr1, 1);
        checkOutput("t1_addr2", rf_addr2, 2);
        checkOutput("t1_busy", instr_ready, 0);
        checkOutput("t1_no_err", err, 0);
        step();
        checkOutput("t1_capt_no_valid", op_valid, 0);
        checkOutput("t1_capt_addr1", rf_addr1, 1);
        step();
        checkOutput("t1_op_valid", op_valid, 1);
        checkOutput("t1_op_a", op_a, 8'h12);
        checkOutput("t1_op_b", op_b, 8'h34);
        res_valid = 1'b1;
        res_data  = 8'h46;
        step();
        checkOutput("t1_wait_no_wr", rf_wr_en, 0);
        step();
        res_valid = 1'b0;
        checkOutput("t1_wr_en", rf_wr_en, 1);
        checkOutput("t1_wr_addr", rf_wr_addr, 3);
        checkOutput("t1_wr_data", rf_wr_data, 8'h46);
        step();
        checkOutput("t1_ready_back", instr_ready, 1);
        checkOutput("t1_wr_off_addr", rf_wr_addr, 0);
        checkOutput("t1_wr_count", wr_count - wr_base, 1);
        checkOutput("t1_r3", regs[3], 8'h46);

        // ALU backpressure: op_ready low for 5 ISSUE cycles.
        hs_base  = hs_count;
        op_ready = 1'b0;
        applyStimulus(8'd2, 8'd1, 8'd5, 1'b1);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_valid", op_valid, 1);
            checkOutput("t2_hold_a", op_a, 8'h34);
            checkOutput("t2_hold_b", op_b, 8'h12);
            if (i < 4) step();
        end
        op_ready  = 1'b1;
        res_valid = 1'b1;
        res_data  = 8'h77;
        step();
        checkOutput("t2_left_issue", op_valid, 0);
        step();
        res_valid = 1'b0;
        checkOutput("t2_wr_en", rf_wr_en, 1);
        checkOutput("t2_wr_data", rf_wr_data, 8'h77);
        step();
        checkOutput("t2_one_handshake", hs_count - hs_base, 1);
        checkOutput("t2_r5", regs[5], 8'h77);

        // No write-back; res_valid kept high is ignored.
        wr_base   = wr_count;
        res_valid = 1'b1;
        res_data  = 8'hAA;
        applyStimulus(8'd3, 8'd5, 8'd6, 1'b0);
        step();
        step();
        checkOutput("t3_op_a", op_a, 8'h46);
        checkOutput("t3_op_b", op_b, 8'h77);
        step();
        checkOutput("t3_idle", instr_ready, 1);
        step();
        step();
        res_valid = 1'b0;
        checkOutput("t3_no_write", wr_count - wr_base, 0);
        checkOutput("t3_r6", regs[6], 0);

        // Out-of-range rs2 and rd.
        wr_base = wr_count;
        applyStimulus(8'd1, 8'd9, 8'd8, 1'b1);
        checkOutput("t4_err_pulse", err, 1);
        step();
        checkOutput("t4_err_gone", err, 0);
        step();
        checkOutput("t4_op_a", op_a, 8'h12);
        checkOutput("t4_op_b_zero", op_b, 0);
        res_valid = 1'b1;
        res_data  = 8'h55;
        step();
        checkOutput("t4_wait_no_wr", rf_wr_en, 0);
        step();
        res_valid = 1'b0;
        checkOutput("t4_back_idle", instr_ready, 1);
        checkOutput("t4_no_write", wr_count - wr_base, 0);

        // Reset while waiting for the result with res_valid high.
        wr_base = wr_count;
        applyStimulus(8'd1, 8'd2, 8'd7, 1'b1);
        step();
        step();
        step();
        checkOutput("t5_in_wait", op_valid, 0);
        res_valid = 1'b1;
        res_data  = 8'h33;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_ready", instr_ready, 1);
        checkOutput("t5_rst_addr1", rf_addr1, 0);
        checkOutput("t5_rst_op_a", op_a, 0);
        checkOutput("t5_rst_wr_en", rf_wr_en, 0);
        step();
        checkOutput("t5_rst_wr_en_edge", rf_wr_en, 0);
        rst       = 1'b0;
        res_valid = 1'b0;
        step();
        checkOutput("t5_no_write", wr_count - wr_base, 0);
        checkOutput("t5_still_idle", instr_ready, 1);

        // Back-to-back: A writes r4=0x99, B reads r4 right after.
        op_ready  = 1'b1;
        res_valid = 1'b1;
        res_data  = 8'h99;
        applyStimulus(8'd0, 8'd0, 8'd4, 1'b1);
        step();
        step();
        step();
        step();
        checkOutput("t6_a_write", rf_wr_en, 1);
        checkOutput("t6_a_addr", rf_wr_addr, 4);
        instr_rs1   = 8'd4;
        instr_rs2   = 8'd2;
        instr_rd    = 8'd6;
        instr_wb    = 1'b0;
        instr_valid = 1'b1;
        step();
        checkOutput("t6_not_consumed", instr_ready, 1);
        step();
        instr_valid = 1'b0;
        checkOutput("t6_b_addr1", rf_addr1, 4);
        step();
        step();
        checkOutput("t6_b_op_a", op_a, 8'h99);
        checkOutput("t6_b_op_b", op_b, 8'h34);
        step();
        res_valid = 1'b0;
        checkOutput("t6_end_idle", instr_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Sequencer that owns both sides of the register file port set: it drives the read-address ports and the write-back port, capturing read data one cycle after the address is presented. It sits between instruction decode and the ALU. It accepts one decoded instruction at a time, fetches its two operands, hands them to the ALU with a valid/ready handshake, and writes the ALU result back into the register file.

## Interface
- NUM_REGS, 8, number of architectural registers; valid indices 0..NUM_REGS-1
- DATA_W, 8, register/data width
- ADDR_W, 8, register-file address port width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  decoded instruction present
- instr_ready  out  1  unit can accept an instruction
- instr_rs1, instr_rs2, instr_rd  in  ADDR_W each  source and destination register indices
- instr_wb  in  1  instruction writes a result back
- rf_addr1, rf_addr2  out  ADDR_W each  register file read addresses
- rf_data1, rf_data2  in  DATA_W each  register file read data; registered, valid one cycle after address
- rf_wr_en  out  1  register file write strobe
- rf_wr_addr  out  ADDR_W  write index
- rf_wr_data  out  DATA_W  write data
- op_valid  out  1  operands valid to ALU
- op_ready  in  1  ALU accepts operands
- op_a, op_b  out  DATA_W each  operands
- res_valid  in  1  ALU result present
- res_data  in  DATA_W  ALU result
- err  out  1  one-cycle pulse: out-of-range register index in the accepted instruction

## Operation
- States: IDLE, READ, CAPT, ISSUE, WAITRES, WRITE.
- IDLE: instr_ready=1. When instr_valid, latch rs1/rs2/rd/wb and go to READ. If any index >= NUM_REGS, pulse err in the next cycle.
- READ: drive rf_addr1=rs1 and rf_addr2=rs2; go to CAPT.
- CAPT: hold the addresses and latch rf_data1/rf_data2 into op_a/op_b. An out-of-range source forces that operand to 0. Go to ISSUE.
- ISSUE: op_valid=1, with op_a/op_b stable until op_valid and op_ready are both high in the same cycle. Then go to WAITRES if wb=1, else IDLE.
- WAITRES: wait for res_valid and latch res_data. Go to WRITE if rd is in range, else IDLE (write suppressed).
- WRITE: rf_wr_en=1 for exactly one cycle, with rf_wr_addr=rd and rf_wr_data=latched result. Go to IDLE.
- Handshake and stall rules:
  - res_valid is ignored outside WAITRES.
  - op_ready outside ISSUE has no effect.
  - instr_valid outside IDLE is not consumed.
- rf_addr1/rf_addr2 hold their last values outside READ/CAPT.
- rf_wr_addr/rf_wr_data are 0 whenever rf_wr_en=0.
- Write-before-read ordering holds: WRITE completes before the next instruction enters READ, so no forwarding is needed.

## Timing
- Reset (asynchronous, effective immediately): state IDLE. Output values during reset:
  - instr_ready=1
  - op_valid=0, rf_wr_en=0, err=0
  - op_a=op_b=0
  - rf_addr1=rf_addr2=rf_wr_addr=rf_wr_data=0
- Reset mid-operation drops the in-flight instruction and any pending write; no partial write occurs.
- Accept edge T (IDLE, instr_valid=1). READ is T+1, CAPT is T+2, and op_valid first rises at T+3.
- Minimum instruction period:
  - wb=0: 4 cycles (IDLE, READ, CAPT, ISSUE) with op_ready=1.
  - wb=1: 6 cycles with op_ready and res_valid both already high.
- err is asserted in cycle T+1 only.
- op_ready held low keeps ISSUE indefinitely, with operands stable.
- res_valid held low keeps WAITRES indefinitely.
- rs1==rs2 is legal; both operands read the same register.
- rd equal to rs1 or rs2 is legal; the write lands after the operands are captured.

## Test plan
- Reset and simple op:
  - Stimulus: after reset, regs r1=0x12, r2=0x34; instr rs1=1, rs2=2, rd=3, wb=1; op_ready=1; res_data=0x46 one cycle after the ALU handshake.
  - Required: rf_addr1=1 and rf_addr2=2 in READ; op_a=0x12, op_b=0x34 with op_valid at T+3; a single rf_wr_en pulse with addr 3, data 0x46; instr_ready returns to 1.
- ALU backpressure:
  - Stimulus: op_ready low for 5 cycles.
  - Required: op_valid stays high and op_a/op_b stay stable throughout; exactly one handshake.
- No write-back:
  - Stimulus: wb=0 instruction.
  - Required: back to IDLE right after the handshake; rf_wr_en never asserts; res_valid pulses are ignored.
- Out of range:
  - Stimulus: rs2=9, rd=8 with NUM_REGS=8.
  - Required: err pulse at T+1; op_b=0; no write issued.
- Reset mid-op:
  - Stimulus: assert rst while in WAITRES with res_valid=1.
  - Required: rf_wr_en stays 0; all outputs go to reset values immediately.
- Back-to-back dependency:
  - Stimulus: instr A writes r4=0x99, then instr B reads rs1=4.
  - Required: B captures op_a=0x99.
